vsync_ctrlr_mc: RTL and testbench

Multi-channel, parametrised vsync controller: synchronises and deglitches NUM_CH independent vsync inputs, emits a one-cycle sync pulse per channel on each active edge, and counts frames per channel until a programmed frame count is reached on all channels. It replaces the single-channel fixed vsync controller behind the reset controller in the capture path. It adds a start/arm handshake, selectable vsync polarity, a stability filter and per-channel frame counters.

---
 rtl/vsync_ctrlr_mc.sv | 212 +++++++++++++++++++++
 tb/tb_vsync_ctrlr_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vsync_ctrlr_mc.sv
// Multi-channel vsync controller: per-channel sync + stability filter, edge pulses and frame counting.
// Optional watchdog/timeout port enabled by defining VSYNC_CTRLR_TIMEOUT_EN.
module vsync_ctrlr_mc #(
    parameter int NUM_CH    = 2,
    parameter int FILT_LEN  = 4,
    parameter int CNT_W     = 8,
    parameter bit VS_POL    = 1'b1,
    parameter int TIMEOUT_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_frames,
    input  logic [NUM_CH-1:0]       vsync,
    output logic [NUM_CH-1:0]       sync_sig,
    output logic [NUM_CH*CNT_W-1:0] frame_cnt,
    output logic                    busy,
    output logic                    finished
`ifdef VSYNC_CTRLR_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    localparam int   FCW   = $clog2(FILT_LEN + 1);
    localparam logic INACT = ~VS_POL;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Out-of-range configurations elaborate this named scope, making them easy to spot
    if (NUM_CH < 1 || NUM_CH > 8 || FILT_LEN < 2 || FILT_LEN > 16 || TIMEOUT_W < 1) begin : g_param_range_violation
    end

    state_t              state_q;
    logic [NUM_CH-1:0]   sync1_q;
    logic [NUM_CH-1:0]   sync2_q;
    logic [NUM_CH-1:0]   filt_q;
    logic [FCW-1:0]      fcnt_q [NUM_CH];
    logic [CNT_W-1:0]    frame_cnt_q [NUM_CH];
    logic [CNT_W-1:0]    target_q;
    logic [NUM_CH-1:0]   sync_sig_q;
    logic                busy_q;
    logic                finished_q;

    logic [NUM_CH-1:0]   rise_s;
    logic [NUM_CH-1:0]   at_tgt_s;
    logic [NUM_CH-1:0]   cnt_en_s;
    logic                all_done_s;
    logic                all_idle_s;
    logic                start_acc_s;
    logic                wd_exp_s;
    logic                tmo_s;

    // Two-flop synchroniser followed by a run-length stability filter per channel
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= {NUM_CH{INACT}};
            sync2_q <= {NUM_CH{INACT}};
            filt_q  <= {NUM_CH{INACT}};
            for (int i = 0; i < NUM_CH; i++) begin
                fcnt_q[i] <= {FCW{1'b0}};
            end
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= {FCW{1'b0}};
                end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= {FCW{1'b0}};
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    // rise_s flags the filter flipping to active on this edge, so the pulse aligns with the flip
    always_comb begin
        rise_s   = {NUM_CH{1'b0}};
        at_tgt_s = {NUM_CH{1'b0}};
        cnt_en_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            rise_s[i]   = (sync2_q[i] != filt_q[i]) && (sync2_q[i] == VS_POL) &&
                          (fcnt_q[i] == FCW'(FILT_LEN - 1));
            at_tgt_s[i] = (frame_cnt_q[i] >= target_q);
            cnt_en_s[i] = (state_q == S_RUN) && rise_s[i] && !at_tgt_s[i];
        end
    end

    assign all_done_s  = &at_tgt_s;
    assign all_idle_s  = (filt_q == {NUM_CH{INACT}}) && (rise_s == {NUM_CH{1'b0}});
    assign start_acc_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign tmo_s       = wd_exp_s && ((state_q == S_ARM) || ((state_q == S_RUN) && !all_done_s));

`ifdef VSYNC_CTRLR_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 timeout_q;

    assign wd_exp_s = &wd_q;
    assign timeout  = timeout_q;

    // Watchdog restarts on entry to ARM/RUN and on every counted edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q      <= {TIMEOUT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            if (start_acc_s) begin
                timeout_q <= 1'b0;
            end else if (tmo_s) begin
                timeout_q <= 1'b1;
            end else begin
                timeout_q <= timeout_q;
            end
            if ((state_q != S_ARM) && (state_q != S_RUN)) begin
                wd_q <= {TIMEOUT_W{1'b0}};
            end else if (((state_q == S_ARM) && all_idle_s) || (|cnt_en_s) || tmo_s) begin
                wd_q <= {TIMEOUT_W{1'b0}};
            end else begin
                wd_q <= wd_q + TIMEOUT_W'(1);
            end
        end
    end
`else
    assign wd_exp_s = 1'b0;
`endif

    // Control FSM with registered status, pulse and counter outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            target_q   <= {CNT_W{1'b0}};
            sync_sig_q <= {NUM_CH{1'b0}};
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                frame_cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync_sig_q <= cnt_en_s;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_en_s[i]) begin
                    frame_cnt_q[i] <= frame_cnt_q[i] + CNT_W'(1);
                end else begin
                    frame_cnt_q[i] <= frame_cnt_q[i];
                end
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target_q <= num_frames;
                        for (int i = 0; i < NUM_CH; i++) begin
                            frame_cnt_q[i] <= {CNT_W{1'b0}};
                        end
                        if (num_frames != {CNT_W{1'b0}}) begin
                            state_q    <= S_ARM;
                            busy_q     <= 1'b1;
                            finished_q <= 1'b0;
                        end else begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            finished_q <= 1'b1;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_ARM: begin
                    if (tmo_s) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end else if (all_idle_s) begin
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_ARM;
                    end
                end
                S_RUN: begin
                    if (all_done_s || tmo_s) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign frame_cnt[g*CNT_W +: CNT_W] = frame_cnt_q[g];
    end

    assign sync_sig = sync_sig_q;
    assign busy     = busy_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_vsync_ctrlr_mc.sv
// Directed self-checking bench for vsync_ctrlr_mc: one active-high and one active-low instance.
module tb_vsync_ctrlr_mc;

    logic        clk;
    logic        reset;
    logic        start0, start1;
    logic [7:0]  nf0, nf1;
    logic [1:0]  vs0, vs1;
    logic [1:0]  ss0, ss1;
    logic [15:0] fc0, fc1;
    logic        busy0, busy1, fin0, fin1;
`ifdef VSYNC_CTRLR_TIMEOUT_EN
    logic        tmo0, tmo1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pc0 [2] = '{0, 0};
    int pc1 [2] = '{0, 0};

    vsync_ctrlr_mc #(.NUM_CH(2), .FILT_LEN(4), .CNT_W(8), .VS_POL(1'b1), .TIMEOUT_W(8)) u0 (
        .clk(clk), .reset(reset), .start(start0), .num_frames(nf0), .vsync(vs0),
        .sync_sig(ss0), .frame_cnt(fc0), .busy(busy0), .finished(fin0)
`ifdef VSYNC_CTRLR_TIMEOUT_EN
        , .timeout(tmo0)
`endif
    );

    vsync_ctrlr_mc #(.NUM_CH(2), .FILT_LEN(4), .CNT_W(8), .VS_POL(1'b0), .TIMEOUT_W(8)) u1 (
        .clk(clk), .reset(reset), .start(start1), .num_frames(nf1), .vsync(vs1),
        .sync_sig(ss1), .frame_cnt(fc1), .busy(busy1), .finished(fin1)
`ifdef VSYNC_CTRLR_TIMEOUT_EN
        , .timeout(tmo1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally per channel, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss0[i]) pc0[i] <= pc0[i] + 1;
            if (ss1[i]) pc1[i] <= pc1[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go0(input logic [7:0] n);
        start0 = 1'b1;
        nf0    = n;
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        int s0, s1, w;
        logic [7:0] fb;
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        nf0 = 8'd0; nf1 = 8'd0; vs0 = 2'b00; vs1 = 2'b11;
        ticks(3);
        chk("rst_sync", ss0, 2'b00);
        chk("rst_cnt", fc0, 16'h0000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_fin", fin0, 1'b0);
        reset = 1'b1;
        tick();

        // Edges in IDLE are ignored
        vs0 = 2'b11; ticks(10); vs0 = 2'b00; ticks(10);
        chk("idle_pulses", pc0[0] + pc0[1], 0);
        chk("idle_cnt", fc0, 16'h0000);

        // Clean frames, 3 per channel, latency FILT_LEN+2
        go0(8'd3);
        chk("a_busy", busy0, 1'b1);
        chk("a_fin", fin0, 1'b0);
        chk("a_cnt0", fc0, 16'h0000);
        ticks(2);
        for (int f = 1; f <= 3; f++) begin
            fb = 8'(f);
            vs0 = 2'b11;
            ticks(5);
            chk("a_pre", ss0, 2'b00);
            tick();
            chk("a_pulse", ss0, 2'b11);
            chk("a_cnt", fc0, {fb, fb});
            if (f == 3) begin
                chk("a_fin_pre", fin0, 1'b0);
                start0 = 1'b1; nf0 = 8'd5;
            end
            tick();
            start0 = 1'b0;
            chk("a_post", ss0, 2'b00);
            if (f == 3) begin
                chk("a_fin_post", fin0, 1'b1);
                chk("a_busy_post", busy0, 1'b0);
                chk("a_cnt_hold", fc0, 16'h0303);
            end
            ticks(3); vs0 = 2'b00; ticks(90);
        end

        // Glitches on ch0 rejected, ch1 stops at target
        s0 = pc0[0]; s1 = pc0[1];
        go0(8'd2);
        ticks(2);
        repeat (2) begin
            vs0 = 2'b10; ticks(10); vs0 = 2'b00; ticks(10);
            vs0 = 2'b01; ticks(2);  vs0 = 2'b00; ticks(10);
            vs0 = 2'b01; ticks(3);  vs0 = 2'b00; ticks(15);
        end
        chk("b_glitch_p0", pc0[0] - s0, 0);
        chk("b_ch1_p", pc0[1] - s1, 2);
        chk("b_cnt", fc0, 16'h0200);
        chk("b_busy", busy0, 1'b1);
        vs0 = 2'b10; ticks(10); vs0 = 2'b00;
        go0(8'd0);
        chk("b_start_ign", busy0, 1'b1);
        chk("b_fin_ign", fin0, 1'b0);
        ticks(10);
        chk("b_ch1_hold_p", pc0[1] - s1, 2);
        chk("b_ch1_hold_c", fc0, 16'h0200);
        repeat (2) begin
            vs0 = 2'b01; ticks(10); vs0 = 2'b00; ticks(20);
        end
        chk("b_cnt_done", fc0, 16'h0202);
        chk("b_ch0_p", pc0[0] - s0, 2);
        chk("b_fin", fin0, 1'b1);
        chk("b_busy_done", busy0, 1'b0);

        // Start mid-frame: the partial frame is skipped
        s0 = pc0[0]; s1 = pc0[1];
        vs0 = 2'b11; ticks(10);
        go0(8'd1);
        chk("c_busy", busy0, 1'b1);
        ticks(10);
        vs0 = 2'b00; ticks(20);
        chk("c_no_pulse", (pc0[0] - s0) + (pc0[1] - s1), 0);
        chk("c_cnt0", fc0, 16'h0000);
        vs0 = 2'b11; ticks(5); tick();
        chk("c_pulse", ss0, 2'b11);
        chk("c_cnt1", fc0, 16'h0101);
        tick();
        chk("c_fin", fin0, 1'b1);
        ticks(5); vs0 = 2'b00; ticks(20);

        // Reset mid-RUN, then a normal run
        go0(8'd3);
        ticks(2);
        vs0 = 2'b11; ticks(6);
        chk("d_cnt_pre", fc0, 16'h0101);
        ticks(2);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("d_rst_cnt", fc0, 16'h0000);
        chk("d_rst_busy", busy0, 1'b0);
        chk("d_rst_fin", fin0, 1'b0);
        chk("d_rst_ss", ss0, 2'b00);
        s0 = pc0[0];
        ticks(10);
        chk("d_idle_np", pc0[0] - s0, 0);
        vs0 = 2'b00; ticks(20);
        go0(8'd1);
        ticks(2);
        vs0 = 2'b11; ticks(6);
        chk("d_cnt", fc0, 16'h0101);
        tick();
        chk("d_fin", fin0, 1'b1);
        ticks(5); vs0 = 2'b00; ticks(20);

        // Zero frame count goes straight to DONE
        go0(8'd0);
        chk("e_fin", fin0, 1'b1);
        chk("e_busy", busy0, 1'b0);
        chk("e_cnt", fc0, 16'h0000);
        tick();
        chk("e_busy2", busy0, 1'b0);

        // Active-low instance counts falling edges only
        s0 = pc1[0];
        start1 = 1'b1; nf1 = 8'd2; tick(); start1 = 1'b0;
        chk("f_busy", busy1, 1'b1);
        ticks(2);
        vs1 = 2'b00; ticks(5);
        chk("f_pre", ss1, 2'b00);
        tick();
        chk("f_pulse", ss1, 2'b11);
        chk("f_cnt1", fc1, 16'h0101);
        ticks(10);
        vs1 = 2'b11; ticks(20);
        chk("f_rise_ign", fc1, 16'h0101);
        chk("f_rise_np", pc1[0] - s0, 1);
        vs1 = 2'b00; ticks(6);
        chk("f_cnt2", fc1, 16'h0202);
        tick();
        chk("f_fin", fin1, 1'b1);
        vs1 = 2'b11; ticks(20);

`ifdef VSYNC_CTRLR_TIMEOUT_EN
        // Watchdog expiry after one frame of three
        go0(8'd3);
        ticks(2);
        vs0 = 2'b11; ticks(6);
        chk("g_cnt_pre", fc0, 16'h0101);
        w = 0;
        while (!fin0 && w < 400) begin
            if (w == 4) vs0 = 2'b00;
            tick();
            w++;
        end
        chk("g_wait", w, 256);
        chk("g_tmo", tmo0, 1'b1);
        chk("g_fin", fin0, 1'b1);
        chk("g_busy", busy0, 1'b0);
        chk("g_cnt", fc0, 16'h0101);
        go0(8'd0);
        chk("g_tmo_clr", tmo0, 1'b0);
`else
        w = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
